// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - keypad key codes, lock FSM state encoding and defaults
package keypad_pkg;

  localparam logic [3:0] KEY_0 = 4'h0;
  localparam logic [3:0] KEY_1 = 4'h1;
  localparam logic [3:0] KEY_2 = 4'h2;
  localparam logic [3:0] KEY_3 = 4'h3;
  localparam logic [3:0] KEY_4 = 4'h4;
  localparam logic [3:0] KEY_5 = 4'h5;
  localparam logic [3:0] KEY_6 = 4'h6;
  localparam logic [3:0] KEY_7 = 4'h7;
  localparam logic [3:0] KEY_8 = 4'h8;
  localparam logic [3:0] KEY_9 = 4'h9;
  localparam logic [3:0] KEY_A = 4'hA;
  localparam logic [3:0] KEY_B = 4'hB;
  localparam logic [3:0] KEY_C = 4'hC;
  localparam logic [3:0] KEY_D = 4'hD;
  localparam logic [3:0] KEY_E = 4'hE;
  localparam logic [3:0] KEY_F = 4'hF;

  localparam logic [3:0] KEY_ENTER = KEY_A;
  localparam logic [3:0] KEY_PROG  = KEY_B;
  localparam logic [3:0] KEY_CLEAR = KEY_C;
  localparam logic [3:0] KEY_BKSP  = KEY_D;
  localparam logic [3:0] KEY_LOCK  = KEY_E;

  // Cycle defaults are held in the 24-bit timer width, so they wrap modulo 2^24
  localparam logic [15:0] DEF_CODE_RESET     = 16'h1234;
  localparam logic [1:0]  DEF_MAX_FAIL       = 2'd3;
  localparam logic [23:0] DEF_LOCKOUT_CYCLES = 24'(50_000_000);
  localparam logic [23:0] DEF_RELOCK_CYCLES  = 24'(250_000_000);

  typedef enum logic [2:0] {
    ST_LOCKED,
    ST_CHECK,
    ST_OPEN,
    ST_PROG,
    ST_LOCKOUT
  } lock_state_e;

  function automatic logic is_digit(input logic [3:0] k);
    return (k <= KEY_9);
  endfunction

endpackage

// File: rtl/keypad_entry_buf.sv
// rtl/keypad_entry_buf.sv - 4-nibble entry shift buffer with push/pop/clear
module keypad_entry_buf (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  logic        pop,
  input  logic        clear,
  input  logic [3:0]  din,
  output logic [15:0] entry,
  output logic [3:0]  entry_valid,
  output logic        full
);

  // clear wins over push, push over pop; valid bits always fill from bit 0
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      entry       <= 16'h0;
      entry_valid <= 4'h0;
    end else if (push) begin
      entry       <= {entry[11:0], din};
      entry_valid <= {entry_valid[2:0], 1'b1};
    end else if (pop && (entry_valid != 4'h0)) begin
      entry       <= {4'h0, entry[15:4]};
      entry_valid <= {1'b0, entry_valid[3:1]};
    end
  end

  assign full = &entry_valid;

endmodule

// File: rtl/keypad_lock_ctrl.sv
// rtl/keypad_lock_ctrl.sv - passcode lock FSM driving lock, alarm and entry display
module keypad_lock_ctrl
  import keypad_pkg::*;
#(
  parameter logic [15:0] CODE_RESET     = DEF_CODE_RESET,
  parameter logic [1:0]  MAX_FAIL       = DEF_MAX_FAIL,
  parameter logic [23:0] LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES,
  parameter logic [23:0] RELOCK_CYCLES  = DEF_RELOCK_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        key_strobe,
  input  logic [3:0]  key_code,
  output logic [15:0] entry,
  output logic [3:0]  entry_valid,
  output logic        unlocked,
  output logic        prog_mode,
  output logic        alarm,
  output logic [1:0]  fail_cnt
);

  lock_state_e state, state_n;
  logic [23:0] timer, timer_n;
  logic [15:0] code;
  logic [1:0]  fail_n;
  logic        buf_push, buf_pop, buf_clear, buf_full, code_load;
  logic        relock_hit;

  keypad_entry_buf u_entry_buf (
    .clk         (clk),
    .reset       (reset),
    .push        (buf_push),
    .pop         (buf_pop),
    .clear       (buf_clear),
    .din         (key_code),
    .entry       (entry),
    .entry_valid (entry_valid),
    .full        (buf_full)
  );

  assign relock_hit = (timer == RELOCK_CYCLES - 24'd1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_LOCKED;
      timer     <= 24'h0;
      code      <= CODE_RESET;
      fail_cnt  <= 2'd0;
      unlocked  <= 1'b0;
      prog_mode <= 1'b0;
      alarm     <= 1'b0;
    end else begin
      state     <= state_n;
      timer     <= timer_n;
      fail_cnt  <= fail_n;
      unlocked  <= (state_n == ST_OPEN) || (state_n == ST_PROG);
      prog_mode <= (state_n == ST_PROG);
      alarm     <= (state_n == ST_LOCKOUT);
      if (code_load) code <= entry;
    end
  end

  always_comb begin
    state_n   = state;
    timer_n   = timer + 24'd1;
    fail_n    = fail_cnt;
    buf_push  = 1'b0;
    buf_pop   = 1'b0;
    buf_clear = 1'b0;
    code_load = 1'b0;
    case (state)
      ST_LOCKED: begin
        timer_n = 24'h0;
        if (key_strobe) begin
          if (is_digit(key_code))          buf_push  = 1'b1;
          else if (key_code == KEY_CLEAR)  buf_clear = 1'b1;
          else if (key_code == KEY_BKSP)   buf_pop   = 1'b1;
          else if (key_code == KEY_ENTER) begin
            if (buf_full) state_n = ST_CHECK;
            else          buf_clear = 1'b1;
          end
        end
      end
      ST_CHECK: begin
        buf_clear = 1'b1;
        if (entry == code) begin
          state_n = ST_OPEN;
          fail_n  = 2'd0;
        end else if (fail_cnt + 2'd1 == MAX_FAIL) begin
          state_n = ST_LOCKOUT;
          fail_n  = MAX_FAIL;
        end else begin
          state_n = ST_LOCKED;
          fail_n  = fail_cnt + 2'd1;
        end
      end
      ST_OPEN: begin
        // relock timeout takes priority over a key arriving the same cycle
        if (relock_hit) begin
          state_n = ST_LOCKED;
        end else if (key_strobe) begin
          timer_n = 24'h0;
          if (key_code == KEY_LOCK) state_n = ST_LOCKED;
          else if (key_code == KEY_PROG) begin
            state_n   = ST_PROG;
            buf_clear = 1'b1;
          end
        end
      end
      ST_PROG: begin
        if (relock_hit) begin
          state_n   = ST_LOCKED;
          buf_clear = 1'b1;
        end else if (key_strobe) begin
          timer_n = 24'h0;
          if (is_digit(key_code))          buf_push  = 1'b1;
          else if (key_code == KEY_CLEAR)  buf_clear = 1'b1;
          else if (key_code == KEY_BKSP)   buf_pop   = 1'b1;
          else if (key_code == KEY_ENTER) begin
            buf_clear = 1'b1;
            if (buf_full) begin
              code_load = 1'b1;
              state_n   = ST_OPEN;
            end
          end else if (key_code == KEY_LOCK) begin
            buf_clear = 1'b1;
            state_n   = ST_LOCKED;
          end
        end
      end
      ST_LOCKOUT: begin
        if (timer == LOCKOUT_CYCLES - 24'd1) begin
          state_n = ST_LOCKED;
          fail_n  = 2'd0;
        end
      end
      default: begin
        state_n   = ST_LOCKED;
        buf_clear = 1'b1;
      end
    endcase
    if (state_n != state) timer_n = 24'h0;
  end

endmodule

// File: tb/tb_keypad_lock_ctrl.sv
// tb/tb_keypad_lock_ctrl.sv - directed self-checking bench for keypad_lock_ctrl
module tb_keypad_lock_ctrl;
  import keypad_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        key_strobe;
  logic [3:0]  key_code;
  logic [15:0] entry;
  logic [3:0]  entry_valid;
  logic        unlocked, prog_mode, alarm;
  logic [1:0]  fail_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  keypad_lock_ctrl #(
    .CODE_RESET     (16'h1234),
    .MAX_FAIL       (2'd3),
    .LOCKOUT_CYCLES (24'd16),
    .RELOCK_CYCLES  (24'd20)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .key_strobe  (key_strobe),
    .key_code    (key_code),
    .entry       (entry),
    .entry_valid (entry_valid),
    .unlocked    (unlocked),
    .prog_mode   (prog_mode),
    .alarm       (alarm),
    .fail_cnt    (fail_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // strobe held across one rising edge; returns at the following falling edge
  task automatic press(input logic [3:0] k);
    @(negedge clk);
    key_strobe = 1'b1;
    key_code   = k;
    @(negedge clk);
    key_strobe = 1'b0;
    key_code   = 4'h0;
  endtask

  task automatic enter4(input logic [15:0] c);
    press(c[15:12]);
    press(c[11:8]);
    press(c[7:4]);
    press(c[3:0]);
    press(KEY_ENTER);
  endtask

  initial begin
    reset      = 1'b1;
    key_strobe = 1'b0;
    key_code   = 4'h0;
    repeat (3) @(negedge clk);
    chk("rst_unlocked", 16'(unlocked), 16'd0);
    chk("rst_alarm", 16'(alarm), 16'd0);
    chk("rst_prog", 16'(prog_mode), 16'd0);
    chk("rst_fail", 16'(fail_cnt), 16'd0);
    chk("rst_entry", entry, 16'h0);
    chk("rst_valid", 16'(entry_valid), 16'h0);
    reset = 1'b0;

    // correct code: one CHECK cycle, then OPEN
    press(1); press(2); press(3); press(4);
    chk("t1_entry", entry, 16'h1234);
    chk("t1_valid", 16'(entry_valid), 16'hF);
    press(KEY_ENTER);
    chk("t1_check_cycle", 16'(unlocked), 16'd0);
    @(negedge clk);
    chk("t1_unlocked", 16'(unlocked), 16'd1);
    chk("t1_fail", 16'(fail_cnt), 16'd0);
    chk("t1_valid_clr", 16'(entry_valid), 16'h0);
    press(KEY_LOCK);
    chk("t1_relocked", 16'(unlocked), 16'd0);

    // three wrong entries -> lockout for 16 cycles
    enter4(16'h5555);
    @(negedge clk);
    chk("t2_fail1", 16'(fail_cnt), 16'd1);
    chk("t2_locked1", 16'(unlocked), 16'd0);
    enter4(16'h5555);
    @(negedge clk);
    chk("t2_fail2", 16'(fail_cnt), 16'd2);
    chk("t2_noalarm", 16'(alarm), 16'd0);
    enter4(16'h5555);
    @(negedge clk);
    chk("t2_alarm", 16'(alarm), 16'd1);
    chk("t2_fail3", 16'(fail_cnt), 16'd3);
    enter4(16'h1234);
    chk("t2_keys_ignored", 16'(entry_valid), 16'h0);
    chk("t2_still_alarm", 16'(alarm), 16'd1);
    repeat (5) @(negedge clk);
    chk("t2_alarm_last", 16'(alarm), 16'd1);
    @(negedge clk);
    chk("t2_alarm_off", 16'(alarm), 16'd0);
    chk("t2_fail_clr", 16'(fail_cnt), 16'd0);
    enter4(16'h1234);
    @(negedge clk);
    chk("t2_unlock", 16'(unlocked), 16'd1);
    press(KEY_LOCK);

    // editing: backspace, overflow, clear, short entry
    press(1); press(2); press(9);
    chk("t3_entry3", entry, 16'h0129);
    press(KEY_BKSP);
    chk("t3_bksp", entry, 16'h0012);
    chk("t3_bksp_valid", 16'(entry_valid), 16'h3);
    press(3); press(4);
    chk("t3_entry", entry, 16'h1234);
    press(KEY_ENTER);
    @(negedge clk);
    chk("t3_unlock", 16'(unlocked), 16'd1);
    press(KEY_LOCK);
    press(1); press(2); press(3); press(4); press(5);
    chk("t3_drop_oldest", entry, 16'h2345);
    press(KEY_CLEAR);
    chk("t3_clear", 16'(entry_valid), 16'h0);
    press(KEY_BKSP);
    chk("t3_bksp_empty", entry, 16'h0);
    press(1); press(2); press(KEY_ENTER);
    chk("t3_short_valid", 16'(entry_valid), 16'h0);
    @(negedge clk);
    chk("t3_short_locked", 16'(unlocked), 16'd0);
    chk("t3_short_fail", 16'(fail_cnt), 16'd0);

    // programming a new code
    enter4(16'h1234);
    @(negedge clk);
    press(KEY_PROG);
    chk("t4_prog", 16'(prog_mode), 16'd1);
    chk("t4_prog_unl", 16'(unlocked), 16'd1);
    press(9); press(8); press(7); press(6);
    chk("t4_prog_entry", entry, 16'h9876);
    press(KEY_ENTER);
    chk("t4_prog_off", 16'(prog_mode), 16'd0);
    chk("t4_open", 16'(unlocked), 16'd1);
    press(KEY_LOCK);
    chk("t4_lock", 16'(unlocked), 16'd0);
    enter4(16'h1234);
    @(negedge clk);
    chk("t4_old_fail", 16'(fail_cnt), 16'd1);
    chk("t4_old_locked", 16'(unlocked), 16'd0);
    enter4(16'h9876);
    @(negedge clk);
    chk("t4_new_unlock", 16'(unlocked), 16'd1);
    chk("t4_fail_clr", 16'(fail_cnt), 16'd0);
    press(KEY_LOCK);

    // relock timeout: 20 idle cycles, extended by a key at cycle 15
    enter4(16'h9876);
    @(negedge clk);
    chk("t5_open", 16'(unlocked), 16'd1);
    repeat (19) @(negedge clk);
    chk("t5_before_to", 16'(unlocked), 16'd1);
    @(negedge clk);
    chk("t5_timeout", 16'(unlocked), 16'd0);
    enter4(16'h9876);
    @(negedge clk);
    repeat (14) @(negedge clk);
    press(KEY_F);
    repeat (19) @(negedge clk);
    chk("t5_ext_before", 16'(unlocked), 16'd1);
    @(negedge clk);
    chk("t5_ext_timeout", 16'(unlocked), 16'd0);

    // reset mid-programming restores the reset code
    enter4(16'h9876);
    @(negedge clk);
    press(KEY_PROG); press(9); press(8);
    chk("t6_prog_entry", entry, 16'h0098);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("t6_rst_unl", 16'(unlocked), 16'd0);
    chk("t6_rst_prog", 16'(prog_mode), 16'd0);
    chk("t6_rst_entry", entry, 16'h0);
    chk("t6_rst_valid", 16'(entry_valid), 16'h0);
    chk("t6_rst_fail", 16'(fail_cnt), 16'd0);
    enter4(16'h9876);
    @(negedge clk);
    chk("t6_code_gone", 16'(fail_cnt), 16'd1);
    enter4(16'h1234);
    @(negedge clk);
    chk("t6_code_reset", 16'(unlocked), 16'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
